// File: rtl/xillybus_ctrl_pkg.sv
// Shared constants and types for the Xillybus control register file.
//   NUM_REGS : size of the 5-bit address space seen by the host
//   RO_BASE  : first read-only (hw_status) address; everything below is RW
//   ERR_REG  : RW register whose upper half shows the read-only write error count
//   GO_REG/GO_BIT : register/bit that fires ctrl_go and always reads back 0
package xillybus_ctrl_pkg;

  localparam int NUM_REGS = 32;
  localparam int RO_BASE  = 28;
  localparam int ERR_REG  = 27;
  localparam int GO_REG   = 0;
  localparam int GO_BIT   = 0;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int ERR_W    = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ERR_W-1:0]  err_t;

  // True for the status words at the top of the map, which the host cannot write.
  function automatic logic is_ro(input addr_t a);
    return a >= addr_t'(RO_BASE);
  endfunction

endpackage

// File: rtl/xillybus_ctrl_regs.sv
// Register file behind a pair of Xillybus addressed streams (xcw_ctrl write,
// xcr_ctrl read). Addresses 0..27 are RW flops, 28..31 map hw_status words.
//
// Ports:
//   bus_clk, trn_reset_n            clock, async active-low reset
//   user_w_xcw_ctrl_*               write stream (wren/data/open, full tied 0)
//   user_xcw_ctrl_addr[_update]     write-stream seek
//   user_r_xcr_ctrl_*               read stream (rden/open, data/empty/eof)
//   user_xcr_ctrl_addr[_update]     read-stream seek
//   hw_status                       NUM_RO application status words (word 0 = addr 28)
//   reg_wr_strobe/addr/data         registered one-cycle echo of every accepted write
//   ctrl_go                         one-cycle pulse on a write of 1 to bit 0 of reg 0
//   ctrl_regs                       flattened view of registers 0..27 (reg i at [32*i +: 32])
module xillybus_ctrl_regs
  import xillybus_ctrl_pkg::*;
#(
  parameter int NUM_RO = 4
) (
  input  logic                      bus_clk,
  input  logic                      trn_reset_n,

  input  logic                      user_w_xcw_ctrl_wren,
  input  logic [DATA_W-1:0]         user_w_xcw_ctrl_data,
  input  logic                      user_w_xcw_ctrl_open,
  input  logic [ADDR_W-1:0]         user_xcw_ctrl_addr,
  input  logic                      user_xcw_ctrl_addr_update,
  output logic                      user_w_xcw_ctrl_full,

  input  logic                      user_r_xcr_ctrl_rden,
  input  logic                      user_r_xcr_ctrl_open,
  input  logic [ADDR_W-1:0]         user_xcr_ctrl_addr,
  input  logic                      user_xcr_ctrl_addr_update,
  output logic [DATA_W-1:0]         user_r_xcr_ctrl_data,
  output logic                      user_r_xcr_ctrl_empty,
  output logic                      user_r_xcr_ctrl_eof,

  input  logic [DATA_W*NUM_RO-1:0]  hw_status,

  output logic                      reg_wr_strobe,
  output logic [ADDR_W-1:0]         reg_wr_addr,
  output logic [DATA_W-1:0]         reg_wr_data,
  output logic                      ctrl_go,
  output logic [DATA_W*RO_BASE-1:0] ctrl_regs
);

  localparam int RO_SLOTS = NUM_REGS - RO_BASE;

  // A register file is always ready and never ends.
  assign user_w_xcw_ctrl_full  = 1'b0;
  assign user_r_xcr_ctrl_empty = 1'b0;
  assign user_r_xcr_ctrl_eof   = 1'b0;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  word_t regs_q [RO_BASE];
  word_t regs_d [RO_BASE];
  addr_t wr_ptr_q, wr_ptr_d;
  addr_t rd_ptr_q, rd_ptr_d;
  err_t  ro_wr_err_q, ro_wr_err_d;
  logic  wr_open_q, rd_open_q;
  word_t rd_data_q, rd_data_d;
  logic  wr_strobe_q, wr_strobe_d;
  addr_t wr_addr_q, wr_addr_d;
  word_t wr_data_q, wr_data_d;
  logic  go_q, go_d;

  // ---------------------------------------------------------------------------
  // Read-only status words; slots beyond NUM_RO read as zero.
  // ---------------------------------------------------------------------------
  word_t ro_words [RO_SLOTS];

  for (genvar g = 0; g < RO_SLOTS; g++) begin : g_ro
    if (g < NUM_RO) begin : g_map
      assign ro_words[g] = hw_status[g*DATA_W +: DATA_W];
    end else begin : g_zero
      assign ro_words[g] = '0;
    end
  end

  // Host-visible RW words: register 27 carries the error counter in its top
  // half. Its stored top half is kept at zero so the OR is exact.
  word_t rw_view [RO_BASE];

  always_comb begin
    for (int i = 0; i < RO_BASE; i++) rw_view[i] = regs_q[i];
    rw_view[ERR_REG] = regs_q[ERR_REG] | {ro_wr_err_q, {(DATA_W-ERR_W){1'b0}}};
  end

  for (genvar g = 0; g < RO_BASE; g++) begin : g_flat
    assign ctrl_regs[g*DATA_W +: DATA_W] = rw_view[g];
  end

  // ---------------------------------------------------------------------------
  // Write stream: a seek in the same cycle as wren takes effect first.
  // ---------------------------------------------------------------------------
  addr_t wr_addr;
  word_t wr_word;

  assign wr_addr = user_xcw_ctrl_addr_update ? user_xcw_ctrl_addr : wr_ptr_q;

  // NOTE: every signal driven here gets a default before any condition, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    regs_d      = regs_q;
    wr_ptr_d    = wr_ptr_q;
    ro_wr_err_d = ro_wr_err_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    go_d        = 1'b0;
    wr_word     = user_w_xcw_ctrl_data;

    if (user_w_xcw_ctrl_wren) begin
      wr_strobe_d = 1'b1;
      wr_addr_d   = wr_addr;
      wr_data_d   = user_w_xcw_ctrl_data;
      wr_ptr_d    = wr_addr + addr_t'(1);   // 5-bit add wraps 31 -> 0

      if (is_ro(wr_addr)) begin
        if (ro_wr_err_q != '1) ro_wr_err_d = ro_wr_err_q + err_t'(1);
      end else begin
        for (int i = 0; i < RO_BASE; i++) begin
          if (wr_addr == addr_t'(i)) begin
            wr_word = user_w_xcw_ctrl_data;
            if (i == ERR_REG) wr_word[DATA_W-1:ERR_W] = '0;
            if (i == GO_REG)  wr_word[GO_BIT] = 1'b0;   // go bit is self-clearing
            regs_d[i] = wr_word;
          end
        end
        go_d = (wr_addr == addr_t'(GO_REG)) && user_w_xcw_ctrl_data[GO_BIT];
      end
    end else if (user_xcw_ctrl_addr_update) begin
      wr_ptr_d = user_xcw_ctrl_addr;
    end

    // Closing the stream rewinds it; register contents survive.
    if (wr_open_q && !user_w_xcw_ctrl_open) wr_ptr_d = '0;
  end

  // ---------------------------------------------------------------------------
  // Read stream: data comes from the current (pre-write) register contents, so
  // a same-cycle read and write of one address returns the old value.
  // ---------------------------------------------------------------------------
  addr_t rd_addr;
  word_t rd_word;

  assign rd_addr = user_xcr_ctrl_addr_update ? user_xcr_ctrl_addr : rd_ptr_q;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < RO_BASE; i++) begin
      if (rd_addr == addr_t'(i)) rd_word = rw_view[i];
    end
    for (int j = 0; j < RO_SLOTS; j++) begin
      if (rd_addr == addr_t'(RO_BASE + j)) rd_word = ro_words[j];
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;   // holds while rden is low
    rd_ptr_d  = rd_ptr_q;
    if (user_r_xcr_ctrl_rden) begin
      rd_data_d = rd_word;
      rd_ptr_d  = rd_addr + addr_t'(1);
    end else if (user_xcr_ctrl_addr_update) begin
      rd_ptr_d = user_xcr_ctrl_addr;
    end
    if (rd_open_q && !user_r_xcr_ctrl_open) rd_ptr_d = '0;
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      // NOTE: the register array is built from flops, so it can be cleared
      // here; an array mapped to RAM could not take an async reset.
      for (int i = 0; i < RO_BASE; i++) regs_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ro_wr_err_q <= '0;
      wr_open_q   <= 1'b0;
      rd_open_q   <= 1'b0;
      rd_data_q   <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      go_q        <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ro_wr_err_q <= ro_wr_err_d;
      wr_open_q   <= user_w_xcw_ctrl_open;
      rd_open_q   <= user_r_xcr_ctrl_open;
      rd_data_q   <= rd_data_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      go_q        <= go_d;
    end
  end

  assign user_r_xcr_ctrl_data = rd_data_q;
  assign reg_wr_strobe        = wr_strobe_q;
  assign reg_wr_addr          = wr_addr_q;
  assign reg_wr_data          = wr_data_q;
  assign ctrl_go              = go_q;

endmodule

// File: doc/xillybus_ctrl_regs.md
XILLYBUS_CTRL_REGS -- requirements
Module: xillybus_ctrl_regs

Interface
REQ-001 SHALL have parameter NUM_RO, default 4: number of read-only status registers at the top of the map (28..31).
REQ-002 SHALL have port bus_clk, input, 1: single clock for all logic.
REQ-003 SHALL have port trn_reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 SHALL have ports user_w_xcw_ctrl_wren / user_w_xcw_ctrl_data / user_w_xcw_ctrl_open, input, 1/32/1: addressed write stream from the core.
REQ-005 SHALL have ports user_xcw_ctrl_addr / user_xcw_ctrl_addr_update, input, 5/1: write-stream seek.
REQ-006 SHALL have port user_w_xcw_ctrl_full, output, 1: write back-pressure.
REQ-007 SHALL have ports user_r_xcr_ctrl_rden / user_r_xcr_ctrl_open, input, 1/1: addressed read stream from the core.
REQ-008 SHALL have ports user_xcr_ctrl_addr / user_xcr_ctrl_addr_update, input, 5/1: read-stream seek.
REQ-009 SHALL have ports user_r_xcr_ctrl_data / user_r_xcr_ctrl_empty / user_r_xcr_ctrl_eof, output, 32/1/1: read data and status.
REQ-010 SHALL have port hw_status, input, 32*NUM_RO: application status words mapped to addresses 28..31.
REQ-011 SHALL have ports reg_wr_strobe / reg_wr_addr / reg_wr_data, output, 1/5/32: one-cycle notification of each accepted write.
REQ-012 SHALL have port ctrl_go, output, 1: one-cycle pulse when bit 0 of register 0 is written as 1.
REQ-013 SHALL have port ctrl_regs, output, 32*28: flattened contents of RW registers 0..27.

Function
REQ-014 SHALL tie user_w_xcw_ctrl_full, user_r_xcr_ctrl_empty and user_r_xcr_ctrl_eof to 0 (a register file never blocks or ends).
REQ-015 SHALL load wr_ptr from user_xcw_ctrl_addr on each cycle with user_xcw_ctrl_addr_update=1.
REQ-016 SHALL, on wren=1 and addr_update=0, write data to wr_ptr if wr_ptr<28, then increment wr_ptr modulo 32 (31->0).
REQ-017 SHALL, when addr_update and wren are both 1 in the same cycle, seek first and write at the new address.
REQ-018 SHALL ignore writes to 28..31 (contents unchanged) but still advance wr_ptr, pulse reg_wr_strobe and increment ro_wr_err.
REQ-019 SHALL assert reg_wr_strobe/addr/data registered, one cycle after the accepted wren.
REQ-020 SHALL store bit 0 of register 0 as 0 always and assert ctrl_go for one cycle, one cycle after a write with data[0]=1.
REQ-021 SHALL load rd_ptr from user_xcr_ctrl_addr on addr_update; on rden=1, register user_r_xcr_ctrl_data <= word[rd_ptr] and increment rd_ptr modulo 32, so data is valid the cycle after rden.
REQ-022 SHALL, when rden and addr_update coincide, seek first and read from the new address.
REQ-023 SHALL return the pre-write value when a read and a write hit the same address in the same cycle.
REQ-024 SHALL hold user_r_xcr_ctrl_data stable while rden=0.
REQ-025 SHALL sample hw_status at the rden edge; no other synchronisation (same clock domain).
REQ-026 SHALL reset wr_ptr to 0 on falling user_w_xcw_ctrl_open, and rd_ptr to 0 on falling user_r_xcr_ctrl_open; register contents are kept.
REQ-027 SHALL keep a 16-bit saturating counter ro_wr_err, readable in bits 31:16 of register 27 (bits 15:0 remain RW).

Reset
REQ-028 SHALL, on trn_reset_n=0, asynchronously clear all registers, wr_ptr, rd_ptr, ro_wr_err, user_r_xcr_ctrl_data, reg_wr_strobe, reg_wr_addr, reg_wr_data and ctrl_go to 0.
REQ-029 SHALL discard a write or read in flight when reset asserts mid-transfer; after release the first access uses pointer 0 unless a seek is given.

Structure
REQ-030 SHALL place NUM_REGS=32, RO_BASE=28, ERR_REG=27 and GO_BIT=0 in shared package xillybus_ctrl_pkg.
REQ-031 SHALL be a single module with no sub-modules; the register array is flops, not BRAM.

Verification
REQ-032 SHALL check: seek 5, write 0xA,0xB,0xC -> regs 5,6,7 = 0xA,0xB,0xC; reg_wr_strobe pulses 3 times with addr 5,6,7.
REQ-033 SHALL check: seek 30, write 4 words -> 30,31 unchanged, 0,1 written (wrap), ro_wr_err=2.
REQ-034 SHALL check: hw_status word 0 = 0xDEADBEEF, seek read 28, rden -> data 0xDEADBEEF on the next cycle, rd_ptr=29.
REQ-035 SHALL check: write 0x1 to reg 0 -> ctrl_go high exactly one cycle; a read of reg 0 returns 0x0.
REQ-036 SHALL check: same-cycle read and write of addr 3 (old 0x11, new 0x22) -> read returns 0x11; next read of 3 returns 0x22.
REQ-037 SHALL check: reset asserted mid-burst -> all outputs 0 immediately; a read of any register afterwards returns 0.
